// File: rtl/trigger_seq_pkg.sv
// Shared definitions for trigger_seq: register map, CTRL and STAGE_CFG bit positions,
// the sequencer state type and the per-stage configuration record.
// Sized for the largest legal configuration (12 matchers, 16 stages).
package trigger_seq_pkg;

  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_MATCH_BASE = 8;
  localparam int ADDR_STAGE_BASE = 32;

  localparam int CTRL_ARM        = 0;
  localparam int CTRL_DISARM     = 1;
  localparam int CTRL_LAST_LSB   = 8;

  localparam int CFG_MODE        = 16;
  localparam int CFG_EDGE        = 17;

  localparam int MAX_TMN         = 12;
  localparam int MAX_TSN         = 16;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

  // select is held at full width; bits at or above TMN always stay 0.
  typedef struct packed {
    logic [MAX_TMN-1:0] sel;
    logic               mode_or;
    logic               edge_en;
  } stage_cfg_t;

endpackage

// File: rtl/trigger_matcher.sv
// One mask/value sample matcher with its own bus decode for MASK and VALUE.
// Latency: hit is combinational from the sample; config writes apply from the next clock.
// Backpressure: none, the parent decides which samples count.
module trigger_matcher
  import trigger_seq_pkg::*;
#(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int IDX = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_wr,
  input  logic [BAW-1:0] i_waddr,
  input  logic [BDW-1:0] i_wdata,
  input  logic [SDW-1:0] i_sample,
  output logic           o_hit
);

  localparam logic [BAW-1:0] A_MASK  = BAW'(ADDR_MATCH_BASE + 2*IDX);
  localparam logic [BAW-1:0] A_VALUE = BAW'(ADDR_MATCH_BASE + 2*IDX + 1);

  logic [SDW-1:0] r_mask;
  logic [SDW-1:0] r_value;

  // Capture MASK/VALUE writes addressed to this matcher.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask  <= '0;
      r_value <= '0;
    end else if (i_wr) begin
      if (i_waddr == A_MASK)  r_mask  <= i_wdata[SDW-1:0];
      if (i_waddr == A_VALUE) r_value <= i_wdata[SDW-1:0];
    end
  end

  // A zero mask compares nothing, so it always hits.
  assign o_hit = ((i_sample ^ r_value) & r_mask) == '0;

endmodule

// File: rtl/trigger_seq.sv
// Multi-stage sequential trigger: passes samples through, tagging stage-advance/fire events.
// Latency: exactly one cycle from accepted input sample to output.
// Backpressure: sti_tready = sto_tready | ~sto_tvalid; output held stable while stalled.
// Optional: define TRIGGER_SEQ_TIMESTAMP_EN to add the fire_stamp output.
module trigger_seq
  import trigger_seq_pkg::*;
#(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int TMN = 4,
  parameter int TSN = 4,
  parameter int TCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [1:0]     sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic           armed,
  output logic           fired
`ifdef TRIGGER_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]    fire_stamp
`endif
);

  logic                 r_wready;
  stage_cfg_t           r_cfg [MAX_TSN];
  logic [TCW-1:0]       r_n   [MAX_TSN];
  logic [3:0]           r_last;
  state_t               r_state;
  logic [3:0]           r_stage;
  logic [TCW-1:0]       r_cnt;
  logic                 r_armed;
  logic                 r_fired;
  logic                 r_prev_cond;
  logic                 r_tvalid;
  logic [1:0]           r_tevent;
  logic [SDW-1:0]       r_tdata;

  logic                 w_wr, w_ctrl_wr, w_arm, w_disarm, w_stage_wr;
  logic [BAW-1:0]       w_soff;
  logic [3:0]           w_sidx;
  logic [3:0]           w_last_req;
  logic [TMN-1:0]       w_hit;
  logic [MAX_TMN-1:0]   w_hit_ext, w_sel_wr;
  stage_cfg_t           w_cfg;
  logic [TCW-1:0]       w_need;
  logic [TCW:0]         w_cnt_inc;
  logic                 w_cond, w_qual, w_accept, w_step, w_adv, w_fire;

  // Bus decode: CTRL pulses and the stage register window.
  assign w_wr       = bus_wvalid & bus_wready;
  assign w_ctrl_wr  = w_wr && (bus_waddr == BAW'(ADDR_CTRL));
  assign w_arm      = w_ctrl_wr & bus_wdata[CTRL_ARM];
  assign w_disarm   = w_ctrl_wr & bus_wdata[CTRL_DISARM];
  assign w_soff     = bus_waddr - BAW'(ADDR_STAGE_BASE);
  assign w_stage_wr = w_wr && (bus_waddr >= BAW'(ADDR_STAGE_BASE)) && (w_soff < BAW'(2*TSN));
  assign w_sidx     = w_soff[4:1];
  assign w_last_req = bus_wdata[CTRL_LAST_LSB +: 4];

  for (genvar gm = 0; gm < TMN; gm++) begin : g_match
    trigger_matcher #(.BDW(BDW), .BAW(BAW), .SDW(SDW), .IDX(gm)) u_match (
      .clk      (clk),
      .rst      (rst),
      .i_wr     (w_wr),
      .i_waddr  (bus_waddr),
      .i_wdata  (bus_wdata),
      .i_sample (sti_tdata),
      .o_hit    (w_hit[gm])
    );
  end

  // Widen hits and incoming select to the fixed config width, unused bits zero.
  always_comb begin
    w_hit_ext          = '0;
    w_hit_ext[TMN-1:0] = w_hit;
    w_sel_wr           = '0;
    w_sel_wr[TMN-1:0]  = bus_wdata[TMN-1:0];
  end

  // Bus ready rises on the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wready <= 1'b0;
    else      r_wready <= 1'b1;
  end
  assign bus_wready = r_wready;

  // Configuration registers; last stage index is clamped into the implemented range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < MAX_TSN; s++) begin
        r_cfg[s] <= '0;
        r_n[s]   <= '0;
      end
      r_last <= '0;
    end else begin
      if (w_ctrl_wr)
        r_last <= (w_last_req > 4'(TSN-1)) ? 4'(TSN-1) : w_last_req;
      if (w_stage_wr) begin
        if (!w_soff[0])
          r_cfg[w_sidx] <= '{sel: w_sel_wr, mode_or: bus_wdata[CFG_MODE],
                             edge_en: bus_wdata[CFG_EDGE]};
        else
          r_n[w_sidx] <= bus_wdata[TCW-1:0];
      end
    end
  end

  // Current-stage condition: empty AND selection is true, empty OR selection is false.
  assign w_cfg     = r_cfg[r_stage];
  assign w_need    = (r_n[r_stage] == '0) ? TCW'(1) : r_n[r_stage];
  assign w_cnt_inc = {1'b0, r_cnt} + (TCW+1)'(1);
  assign w_cond    = w_cfg.mode_or ? |(w_hit_ext & w_cfg.sel) : &(w_hit_ext | ~w_cfg.sel);
  assign w_qual    = w_cond & ~(w_cfg.edge_en & r_prev_cond);
  assign w_accept  = sti_tvalid & sti_tready;
  assign w_step    = w_accept & (r_state == ARMED) & w_qual;
  assign w_adv     = w_step & (w_cnt_inc >= {1'b0, w_need});
  assign w_fire    = w_adv & (r_stage == r_last);

  // Sequencer: disarm beats arm; arm restarts from stage 0 in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_fired     <= 1'b0;
      r_prev_cond <= 1'b0;
    end else if (w_disarm) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_fired <= 1'b0;
    end else if (w_arm) begin
      r_state     <= ARMED;
      r_stage     <= '0;
      r_cnt       <= '0;
      r_armed     <= 1'b1;
      r_fired     <= 1'b0;
      r_prev_cond <= 1'b0;
    end else begin
      if (w_accept) r_prev_cond <= w_cond;
      case (r_state)
        ARMED: begin
          if (w_step) begin
            if (w_adv) begin
              r_cnt <= '0;
              if (w_fire) begin
                r_state <= FIRED;
                r_armed <= 1'b0;
                r_fired <= 1'b1;
              end else begin
                r_stage <= r_stage + 4'd1;
              end
            end else if (r_cnt != '1) begin
              r_cnt <= w_cnt_inc[TCW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output register stage: load on accept, drop valid once the sink has taken it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tvalid <= 1'b0;
      r_tevent <= 2'b00;
      r_tdata  <= '0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tevent <= {w_fire, w_adv};
      r_tdata  <= sti_tdata;
    end else if (sto_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign sti_tready = sto_tready | ~r_tvalid;
  assign sto_tvalid = r_tvalid;
  assign sto_tevent = r_tevent;
  assign sto_tdata  = r_tdata;
  assign armed      = r_armed;
  assign fired      = r_fired;

`ifdef TRIGGER_SEQ_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_stamp;

  // Accepted-sample counter since arm; its value at the firing sample is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts    <= '0;
      r_stamp <= '0;
    end else if (w_arm & ~w_disarm) begin
      r_ts    <= '0;
      r_stamp <= '0;
    end else if (w_accept) begin
      r_ts <= r_ts + 32'd1;
      if (w_fire) r_stamp <= r_ts;
    end
  end
  assign fire_stamp = r_stamp;
`endif

endmodule
